// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (OR/AND/XOR/NOT) between two requesters.
// Optional grant counters are enabled by defining LOGIC_ARB_STATS_EN.
module logic_unit_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [1:0]         r0_op,
  input  logic [WIDTH-1:0]   r0_x,
  input  logic [WIDTH-1:0]   r0_y,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [1:0]         r1_op,
  input  logic [WIDTH-1:0]   r1_x,
  input  logic [WIDTH-1:0]   r1_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               busy
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   gnt0_cnt,
  output logic [CNT_W-1:0]   gnt1_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic               last_gnt;
  logic               gnt_sel;
  logic               idle;
  logic               acc0;
  logic               acc1;
  logic [1:0]         cap_op;
  logic [WIDTH-1:0]   cap_x;
  logic [WIDTH-1:0]   cap_y;
  logic               cap_id;
  logic [2*WIDTH-1:0] result;

  // Handshakes: a command transfers on a cycle where rN_valid and rN_ready are
  // both high; the response transfers on a cycle where rsp_valid and rsp_ready are
  // both high. rsp_id/rsp_data are stable while rsp_valid waits for rsp_ready.
  assign idle = (state == IDLE);
  assign busy = ~idle;

  always_comb begin
    gnt_sel = 1'b0;
    if (r0_valid && r1_valid) gnt_sel = ~last_gnt;
    else                      gnt_sel = r1_valid;
  end

  assign r0_ready = idle & r0_valid & ~gnt_sel;
  assign r1_ready = idle & r1_valid &  gnt_sel;
  assign acc0     = r0_valid & r0_ready;
  assign acc1     = r1_valid & r1_ready;

  // NOT inverts the full concatenated operand pair; the others zero-extend.
  always_comb begin
    result = '0;
    case (cap_op)
      2'b00:   result = {{WIDTH{1'b0}}, cap_x | cap_y};
      2'b01:   result = {{WIDTH{1'b0}}, cap_x & cap_y};
      2'b10:   result = {{WIDTH{1'b0}}, cap_x ^ cap_y};
      default: result = ~{cap_x, cap_y};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cap_op    <= '0;
      cap_x     <= '0;
      cap_y     <= '0;
      cap_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0 || acc1) begin
            state    <= EXEC;
            cap_op   <= acc1 ? r1_op : r0_op;
            cap_x    <= acc1 ? r1_x  : r0_x;
            cap_y    <= acc1 ? r1_y  : r0_y;
            cap_id   <= acc1;
            last_gnt <= acc1;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (acc0 && (gnt0_cnt != {CNT_W{1'b1}})) gnt0_cnt <= gnt0_cnt + 1'b1;
      if (acc1 && (gnt1_cnt != {CNT_W{1'b1}})) gnt1_cnt <= gnt1_cnt + 1'b1;
    end
  end
`endif

endmodule
